// File: rtl/seq_scan_ctrl.sv
// Parallel-load front end for the serial "101" Moore detector: shifts a word MSB-first
// through the detector and counts overlapping matches. Optional abort input: SEQ_SCAN_ABORT_EN.
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SEQ_SCAN_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic             match_pulse,
  output logic             serial_bit,
  output logic [1:0]       det_state
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} ctrl_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

  ctrl_t            state, state_nxt;
  det_t             det, det_nxt;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bitcnt;
  logic             abort_req;
  logic             scanning;

`ifdef SEQ_SCAN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  function automatic det_t det_step(input det_t s, input logic b);
    det_t n;
    case (s)
      S0:      n = b ? S1 : S0;
      S1:      n = b ? S1 : S2;
      S2:      n = b ? S3 : S0;
      default: n = b ? S1 : S2;
    endcase
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign scanning = (state == SHIFT) || (state == FLUSH);

  always_comb begin
    state_nxt = state;
    det_nxt   = det;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          det_nxt   = S0;
        end
      end
      SHIFT: begin
        det_nxt = det_step(det, sreg[WIDTH-1]);
        if (bitcnt == BW'(WIDTH - 1)) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (abort_req && scanning) begin
      state_nxt = IDLE;
      det_nxt   = S0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      det         <= S0;
      match_count <= '0;
      sreg        <= '0;
      bitcnt      <= '0;
    end else begin
      state <= state_nxt;
      det   <= det_nxt;
      if (state == IDLE && start) begin
        sreg        <= data_in;
        match_count <= '0;
        bitcnt      <= '0;
      end else begin
        if (state == SHIFT) begin
          sreg   <= {sreg[WIDTH-2:0], 1'b0};
          bitcnt <= bitcnt + BW'(1);
        end
        // FLUSH still counts, so a match closed by the last bit is not lost
        if (scanning && det == S3) match_count <= sat_inc(match_count);
      end
    end
  end

  assign busy        = scanning;
  assign done        = (state == DONE);
  assign match_pulse = scanning && (det == S3);
  assign serial_bit  = (state == SHIFT) ? sreg[WIDTH-1] : 1'b0;
  assign det_state   = det;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: table of scan words plus hand-written
// sequences for held start, mid-scan reset, counter saturation and abort.
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] data_in;
  logic       busy, done, match_pulse, serial_bit;
  logic [3:0] match_count;
  logic [1:0] det_state;
  logic       busy1, done1, mp1, sb1;
  logic [0:0] mc1;
  logic [1:0] ds1;
`ifdef SEQ_SCAN_ABORT_EN
  logic       abort;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
`ifdef SEQ_SCAN_ABORT_EN
    .abort(abort),
`endif
    .start(start), .data_in(data_in), .busy(busy), .done(done),
    .match_count(match_count), .match_pulse(match_pulse),
    .serial_bit(serial_bit), .det_state(det_state)
  );

  seq_scan_ctrl #(.WIDTH(8), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst),
`ifdef SEQ_SCAN_ABORT_EN
    .abort(abort),
`endif
    .start(start), .data_in(data_in), .busy(busy1), .done(done1),
    .match_count(mc1), .match_pulse(mp1),
    .serial_bit(sb1), .det_state(ds1)
  );

  typedef struct {
    logic [7:0] d;
    int         cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start accepted at edge 0; samples below are taken inside cycles 1..11.
  task automatic run_scan(input logic [7:0] d, input int exp_cnt);
    int pulses;
    bit saw_s3, busy_ok, done_ok, ser_ok;
    pulses = 0; saw_s3 = 0; busy_ok = 1; done_ok = 1; ser_ok = 1;
    start = 1'b1;
    data_in = d;
    tick();
    start = 1'b0;
    chk("count_cleared_at_start", match_count, 0);
    for (int c = 1; c <= 9; c++) begin
      if (busy !== 1'b1) busy_ok = 0;
      if (done !== 1'b0) done_ok = 0;
      if (c <= 8 && serial_bit !== d[8-c]) ser_ok = 0;
      if (c == 9 && serial_bit !== 1'b0) ser_ok = 0;
      if (match_pulse === 1'b1) pulses++;
      if (det_state === 2'd3) saw_s3 = 1;
      tick();
    end
    chk("busy_cycles_1_9", busy_ok, 1);
    chk("no_done_while_busy", done_ok, 1);
    chk("serial_bit_order", ser_ok, 1);
    chk("match_pulse_count", pulses, exp_cnt);
    chk("det_reached_s3", saw_s3, (exp_cnt > 0) ? 1 : 0);
    chk("done_cycle_10", done, 1);
    chk("busy_low_in_done", busy, 0);
    chk("match_count", match_count, exp_cnt);
    chk("match_count_sat1", mc1, (exp_cnt > 0) ? 1 : 0);
    tick();
    chk("done_one_cycle", done, 0);
    chk("match_count_holds", match_count, exp_cnt);
  endtask

  initial begin
    int first_done, second_done;
    bit no_done;
    vecs[0] = '{8'b10101010, 3};
    vecs[1] = '{8'b10100101, 2};
    vecs[2] = '{8'b11111111, 0};
    vecs[3] = '{8'b00000000, 0};
    vecs[4] = '{8'b00010101, 2};

    rst = 1'b1; start = 1'b0; data_in = 8'h00;
`ifdef SEQ_SCAN_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", match_count, 0);
    chk("reset_det", det_state, 0);
    chk("reset_serial", serial_bit, 0);
    chk("reset_pulse", match_pulse, 0);
    rst = 1'b0;
    tick();
    chk("idle_no_start", busy, 0);

    for (int i = 0; i < 5; i++) run_scan(vecs[i].d, vecs[i].cnt);

    // start held high: rescans only from IDLE, done spaced 11 cycles
    first_done = 0; second_done = 0;
    start = 1'b1;
    data_in = 8'b00000101;
    tick();
    for (int c = 1; c <= 25; c++) begin
      if (done === 1'b1) begin
        chk("held_start_count", match_count, 1);
        if (first_done == 0) first_done = c;
        else if (second_done == 0) second_done = c;
      end
      if (c == 11) chk("held_start_idle_gap", busy, 0);
      tick();
    end
    start = 1'b0;
    chk("held_first_done", first_done, 10);
    chk("held_second_done", second_done, 21);
    for (int c = 0; c < 12; c++) tick();
    chk("held_back_idle", busy, 0);

    // rst in SHIFT cycle 4
    start = 1'b1;
    data_in = 8'b10101010;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_reset_det_s3", det_state, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midscan_reset_busy", busy, 0);
    chk("midscan_reset_count", match_count, 0);
    chk("midscan_reset_det", det_state, 0);
    no_done = 1;
    for (int c = 0; c < 10; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) no_done = 0;
      tick();
    end
    chk("midscan_reset_stays_idle", no_done, 1);
    run_scan(8'b10101010, 3);

`ifdef SEQ_SCAN_ABORT_EN
    start = 1'b1;
    data_in = 8'b10101010;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("abort_pre_count", match_count, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_det", det_state, 0);
    chk("abort_count_kept", match_count, 1);
    chk("abort_count_kept_sat1", mc1, 1);
    no_done = 1;
    for (int c = 0; c < 12; c++) begin
      if (done !== 1'b0) no_done = 0;
      tick();
    end
    chk("abort_no_done", no_done, 1);
    run_scan(8'b10100101, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
